sp_vacc: RTL and testbench

- Vector accumulator controller that drives one external single-port, read-before-write block RAM instance (`sp_ram`, read latency RAM_LATENCY) over its addr/we/din/dout ports.
- Integrates acc_len consecutive vectors of VLEN = 2**A_WIDTH signed samples, element by element. On the final pass of each integration it emits the summed vector.
- Sits directly upstream of the RAM and consumes its read data; feeds downstream packetiser/readout logic.
- Read-modify-write on a single port works by writing each result into the slot being issued RAM_LATENCY cycles after its read, so the storage base rotates by RAM_LATENCY each pass.

---
 rtl/sp_vacc.sv | 219 +++++++++++++++++++++
 tb/tb_sp_vacc.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/sp_vacc.sv
// Vector accumulator driving one external single-port read-before-write RAM.
// Each result is written into the slot issued RAM_LATENCY cycles after its read, so the storage base rotates every pass.
module sp_vacc #(
  parameter int IN_WIDTH    = 18,
  parameter int D_WIDTH     = 32,
  parameter int A_WIDTH     = 10,
  parameter int RAM_LATENCY = 2,
  parameter int LEN_WIDTH   = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [LEN_WIDTH-1:0]       acc_len,
  input  logic signed [IN_WIDTH-1:0] din,
  input  logic                       din_valid,
  output logic                       din_ready,
  output logic [A_WIDTH-1:0]         ram_addr,
  output logic                       ram_we,
  output logic [D_WIDTH-1:0]         ram_din,
  input  logic [D_WIDTH-1:0]         ram_dout,
  output logic [D_WIDTH-1:0]         dout,
  output logic                       dout_valid,
  output logic                       dout_last,
  output logic                       gap_err,
  output logic                       ovf
);

  localparam int JW = (RAM_LATENCY > 1) ? $clog2(RAM_LATENCY) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_next;
  logic [A_WIDTH-1:0]     r_base;
  logic [A_WIDTH-1:0]     r_k;
  logic [A_WIDTH-1:0]     r_addr;
  logic [LEN_WIDTH-1:0]   r_pass;
  logic [LEN_WIDTH-1:0]   r_len;
  logic [JW-1:0]          r_j;
  logic                   r_first;
  logic                   r_final;

  logic                   w_accept;
  logic                   w_last_elem;
  logic                   w_flush_done;
  logic signed [IN_WIDTH-1:0] w_sample;
  logic [LEN_WIDTH-1:0]   w_len_in;
  logic [LEN_WIDTH-1:0]   w_len_eff;
  logic                   w_first_now;
  logic                   w_final_now;

  // Per-element pipeline from accept to result, RAM_LATENCY+1 stages deep.
  logic                       r_pv     [0:RAM_LATENCY];
  logic                       r_pfirst [0:RAM_LATENCY];
  logic                       r_pfinal [0:RAM_LATENCY];
  logic                       r_plast  [0:RAM_LATENCY];
  logic signed [IN_WIDTH-1:0] r_ps     [0:RAM_LATENCY];

  logic signed [D_WIDTH-1:0] w_old;
  logic signed [D_WIDTH-1:0] w_addend;
  logic signed [D_WIDTH-1:0] w_sum;
  logic                      w_ovf;
  logic                      w_emit;

  logic [D_WIDTH-1:0] r_dout;
  logic               r_dout_valid;
  logic               r_dout_last;
  logic               r_gap;
  logic               r_ovf;

  assign w_accept     = ((r_state == S_IDLE) && din_valid) || (r_state == S_ACCUM);
  assign w_last_elem  = (r_k == {A_WIDTH{1'b1}});
  assign w_flush_done = (r_state == S_FLUSH) && (r_j == JW'(RAM_LATENCY - 1));
  assign w_sample     = ((r_state == S_ACCUM) && !din_valid) ? '0 : din;
  assign w_len_in     = (acc_len == '0) ? LEN_WIDTH'(1) : acc_len;
  assign w_len_eff    = (r_pass == '0) ? w_len_in : r_len;
  // Pass flags are computed once at element 0 and then held for the whole vector.
  assign w_first_now  = (r_state == S_IDLE) ? (r_pass == '0) : r_first;
  assign w_final_now  = (r_state == S_IDLE) ? (r_pass == (w_len_eff - LEN_WIDTH'(1))) : r_final;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    din_ready    = 1'b1;
    case (r_state)
      S_IDLE: begin
        if (din_valid) w_state_next = S_ACCUM;
      end
      S_ACCUM: begin
        if (w_last_elem) w_state_next = S_FLUSH;
      end
      S_FLUSH: begin
        din_ready = 1'b0;
        if (w_flush_done) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_k     <= '0;
      r_base  <= '0;
      r_pass  <= '0;
      r_len   <= LEN_WIDTH'(1);
      r_j     <= '0;
      r_first <= 1'b0;
      r_final <= 1'b0;
      r_addr  <= '0;
    end else begin
      if (w_accept) begin
        r_k <= r_k + 1'b1;
      end
      if ((r_state == S_IDLE) && din_valid) begin
        r_first <= w_first_now;
        r_final <= w_final_now;
        if (r_pass == '0) r_len <= w_len_in;
      end
      if (r_state == S_FLUSH) begin
        if (w_flush_done) begin
          r_j    <= '0;
          r_base <= r_base + A_WIDTH'(RAM_LATENCY);
          r_pass <= r_final ? '0 : r_pass + 1'b1;
        end else begin
          r_j <= r_j + 1'b1;
        end
      end
      // Flush slots wrap to the start of the current base, i.e. base+VLEN+j.
      if (w_accept) begin
        r_addr <= r_base + r_k;
      end else if (r_state == S_FLUSH) begin
        r_addr <= r_base + A_WIDTH'(r_j);
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi <= RAM_LATENCY; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            r_pv[0]     <= 1'b0;
            r_pfirst[0] <= 1'b0;
            r_pfinal[0] <= 1'b0;
            r_plast[0]  <= 1'b0;
            r_ps[0]     <= '0;
          end else begin
            r_pv[0]     <= w_accept;
            r_pfirst[0] <= w_first_now;
            r_pfinal[0] <= w_final_now;
            r_plast[0]  <= w_accept && w_last_elem;
            r_ps[0]     <= w_sample;
          end
        end
      end else begin : g_tail
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            r_pv[gi]     <= 1'b0;
            r_pfirst[gi] <= 1'b0;
            r_pfinal[gi] <= 1'b0;
            r_plast[gi]  <= 1'b0;
            r_ps[gi]     <= '0;
          end else begin
            r_pv[gi]     <= r_pv[gi-1];
            r_pfirst[gi] <= r_pfirst[gi-1];
            r_pfinal[gi] <= r_pfinal[gi-1];
            r_plast[gi]  <= r_plast[gi-1];
            r_ps[gi]     <= r_ps[gi-1];
          end
        end
      end
    end
  endgenerate

  // The first pass never trusts RAM, so stale contents need no clearing.
  assign w_old    = r_pfirst[RAM_LATENCY] ? '0 : ram_dout;
  assign w_addend = D_WIDTH'(r_ps[RAM_LATENCY]);
  assign w_sum    = w_old + w_addend;
  assign w_ovf    = (w_old[D_WIDTH-1] == w_addend[D_WIDTH-1]) &&
                    (w_sum[D_WIDTH-1] != w_old[D_WIDTH-1]);
  assign w_emit   = r_pv[RAM_LATENCY] && r_pfinal[RAM_LATENCY];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_dout_last  <= 1'b0;
      r_gap        <= 1'b0;
      r_ovf        <= 1'b0;
    end else begin
      r_dout_valid <= w_emit;
      r_dout_last  <= w_emit && r_plast[RAM_LATENCY];
      if (w_emit) r_dout <= w_sum;
      if ((r_state == S_ACCUM) && !din_valid) r_gap <= 1'b1;
      if (r_pv[RAM_LATENCY] && w_ovf) r_ovf <= 1'b1;
    end
  end

  assign ram_addr   = r_addr;
  assign ram_we     = r_pv[RAM_LATENCY];
  assign ram_din    = r_pv[RAM_LATENCY] ? w_sum : '0;
  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign dout_last  = r_dout_last;
  assign gap_err    = r_gap;
  assign ovf        = r_ovf;

endmodule

// File: tb/tb_sp_vacc.sv
// Directed bench for sp_vacc with a behavioural read-before-write RAM and an output scoreboard.
module tb_sp_vacc;
  localparam int IW   = 18;
  localparam int DW   = 18;
  localparam int AW   = 3;
  localparam int RL   = 2;
  localparam int LW   = 16;
  localparam int VLEN = 8;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [LW-1:0]        acc_len = '0;
  logic signed [IW-1:0] din = '0;
  logic                 din_valid = 1'b0;
  logic                 din_ready;
  logic [AW-1:0]        ram_addr;
  logic                 ram_we;
  logic [DW-1:0]        ram_din;
  logic [DW-1:0]        ram_dout;
  logic [DW-1:0]        dout;
  logic                 dout_valid;
  logic                 dout_last;
  logic                 gap_err;
  logic                 ovf;

  always #5 clk = ~clk;

  sp_vacc #(
    .IN_WIDTH(IW), .D_WIDTH(DW), .A_WIDTH(AW), .RAM_LATENCY(RL), .LEN_WIDTH(LW)
  ) dut (
    .clk(clk), .rst(rst), .acc_len(acc_len), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din),
    .ram_dout(ram_dout), .dout(dout), .dout_valid(dout_valid), .dout_last(dout_last),
    .gap_err(gap_err), .ovf(ovf)
  );

  // Two-cycle read-before-write RAM
  logic [DW-1:0] mem [0:VLEN-1];
  logic [DW-1:0] q1 = '0;
  logic [DW-1:0] q2 = '0;
  always @(posedge clk) begin
    q1 <= mem[ram_addr];
    q2 <= q1;
    if (ram_we) mem[ram_addr] <= ram_din;
  end
  assign ram_dout = q2;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int first_dv = -1;
  int q_val[$];
  bit q_last[$];
  int vals[VLEN];
  int expv[VLEN];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic monitor();
    int ev;
    bit el;
    logic [DW-1:0] ed;
    if (dout_valid) begin
      if (first_dv < 0) first_dv = cyc;
      chk("dout_valid_expected", 32'(dout_valid), 32'(q_val.size() != 0));
      if (q_val.size() != 0) begin
        ev = q_val.pop_front();
        el = q_last.pop_front();
        ed = DW'(ev);
        chk("dout", 32'(dout), 32'(ed));
        chk("dout_last", 32'(dout_last), 32'(el));
        $display("out cyc=%0d dout=%0d last=%0d exp=%0d", cyc, $signed(dout), dout_last, ev);
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic drain(input int n);
    repeat (n) tick();
    chk("scoreboard_empty", 32'(q_val.size()), 0);
  endtask

  task automatic send_vec(input int gap_k, input bit fin, input bit hold,
                          output int waits, output int c0);
    waits = 0;
    din_valid = hold;
    din = IW'(vals[0]);
    while (!din_ready && waits < 20) begin
      tick();
      waits++;
    end
    chk("din_ready_before_vec", 32'(din_ready), 1);
    if (fin) begin
      for (int k = 0; k < VLEN; k++) begin
        q_val.push_back(expv[k]);
        q_last.push_back(k == VLEN - 1);
      end
    end
    c0 = cyc;
    for (int k = 0; k < VLEN; k++) begin
      din_valid = (k != gap_k);
      din = IW'(vals[k]);
      tick();
    end
    din_valid = hold;
    $display("vec acc_len=%0d gap_k=%0d final=%0d waits=%0d", acc_len, gap_k, fin, waits);
  endtask

  task automatic check_reset_outputs();
    chk("rst_din_ready", 32'(din_ready), 1);
    chk("rst_dout_valid", 32'(dout_valid), 0);
    chk("rst_dout", 32'(dout), 0);
    chk("rst_dout_last", 32'(dout_last), 0);
    chk("rst_ram_we", 32'(ram_we), 0);
    chk("rst_ram_din", 32'(ram_din), 0);
    chk("rst_ram_addr", 32'(ram_addr), 0);
    chk("rst_gap_err", 32'(gap_err), 0);
    chk("rst_ovf", 32'(ovf), 0);
  endtask

  initial begin
    int w;
    int c0;
    int n;

    rst = 1'b1;
    acc_len = LW'(1);
    repeat (3) tick();
    check_reset_outputs();
    rst = 1'b0;
    tick();

    // Single-pass integration, latency and flush window
    acc_len = LW'(1);
    for (int k = 0; k < VLEN; k++) begin vals[k] = k + 1; expv[k] = k + 1; end
    first_dv = -1;
    send_vec(-1, 1'b1, 1'b0, w, c0);
    n = 0;
    while (!din_ready && n < 10) begin tick(); n++; end
    chk("flush_ready_low_cycles", 32'(n), 2);
    drain(10);
    chk("first_output_latency", 32'(first_dv - c0), 4);

    // Three passes with idle gaps
    acc_len = LW'(3);
    for (int k = 0; k < VLEN; k++) begin vals[k] = k + 1; expv[k] = 3 * (k + 1); end
    for (int p = 0; p < 3; p++) begin
      send_vec(-1, p == 2, 1'b0, w, c0);
      repeat (3) tick();
    end
    drain(10);

    // Back-to-back vectors with din_valid held high
    acc_len = LW'(2);
    for (int k = 0; k < VLEN; k++) begin vals[k] = k + 1; expv[k] = 2 * (k + 1); end
    for (int v = 0; v < 8; v++) begin
      send_vec(-1, (v % 2) == 1, 1'b1, w, c0);
      if (v > 0) chk("b2b_ready_low_cycles", 32'(w), 2);
    end
    din_valid = 1'b0;
    drain(12);

    // Gap in the final pass
    chk("gap_err_before", 32'(gap_err), 0);
    acc_len = LW'(2);
    for (int k = 0; k < VLEN; k++) begin vals[k] = 5; expv[k] = (k == 3) ? 5 : 10; end
    send_vec(-1, 1'b0, 1'b0, w, c0);
    send_vec(3, 1'b1, 1'b0, w, c0);
    drain(12);
    chk("gap_err_after", 32'(gap_err), 1);

    // Mixed-sign samples, no overflow
    for (int k = 0; k < VLEN; k++) begin vals[k] = k - 4; expv[k] = 2 * (k - 4); end
    send_vec(-1, 1'b0, 1'b0, w, c0);
    send_vec(-1, 1'b1, 1'b0, w, c0);
    drain(12);
    chk("ovf_before", 32'(ovf), 0);

    // Overflow wraps at the word width
    for (int k = 0; k < VLEN; k++) begin vals[k] = 131071; expv[k] = -2; end
    send_vec(-1, 1'b0, 1'b0, w, c0);
    send_vec(-1, 1'b1, 1'b0, w, c0);
    drain(12);
    chk("ovf_after", 32'(ovf), 1);

    // Reset in the middle of pass 1, then a fresh single-pass vector
    acc_len = LW'(4);
    for (int k = 0; k < VLEN; k++) begin vals[k] = 1; expv[k] = 0; end
    send_vec(-1, 1'b0, 1'b0, w, c0);
    repeat (2) tick();
    din_valid = 1'b1;
    din = IW'(1);
    repeat (3) tick();
    rst = 1'b1;
    #1;
    check_reset_outputs();
    din_valid = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    acc_len = LW'(1);
    for (int k = 0; k < VLEN; k++) begin vals[k] = 7; expv[k] = 7; end
    send_vec(-1, 1'b1, 1'b0, w, c0);
    drain(12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
